// File: rtl/wb_j1_shared_mem_slave_pkg.sv
// Shared types and constants for the J1 shared-memory Wishbone responder.
// FSM state encodings, port-grant tag, data/PC widths and address range helper.
package wb_j1_shared_mem_slave_pkg;

   localparam int DataWidth = 32;
   localparam int PcWidth   = 14;

   localparam logic [DataWidth-1:0] ZeroWord = '0;

   typedef enum logic [1:0] {
      SM_IDLE   = 2'd0,
      SM_ACCESS = 2'd1,
      SM_WAIT   = 2'd2,
      SM_RESP   = 2'd3
   } sm_e;

   typedef enum logic {
      PORT_DATA = 1'b0,
      PORT_INST = 1'b1
   } port_e;

   // Any set bit above the RAM index width means the address misses the RAM.
   function automatic logic adr_oor(input logic [31:0] adr, input int aw);
      return (adr >> aw) != 32'd0;
   endfunction

endpackage

// File: rtl/wb_spram.sv
// Single-port synchronous word RAM, one-cycle read latency, write-first.
// Ports: clk, en (access enable), we (write), adr, wdat, rdat (held while en=0).
module wb_spram #(
   parameter int AW = 12,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] adr,
   input  logic [DW-1:0] wdat,
   output logic [DW-1:0] rdat
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[adr] <= wdat;
            rdat     <= wdat;
         end else begin
            rdat     <= mem[adr];
         end
      end
   end

endmodule

// File: rtl/wb_j1_shared_mem_slave.sv
// Wishbone responder serving a J1 data port and fetch port from one RAM.
// Ports: clk, rst (async active-low), cyc_i/we_i/adr_i/dat_i/dat_o/ack_o data port,
// inst_cyc_i/inst_pc_i/inst_o/inst_ack_o fetch port. Data wins ties.
module wb_j1_shared_mem_slave
   import wb_j1_shared_mem_slave_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int PC_W        = PcWidth,
   parameter int WAIT_STATES = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cyc_i,
   input  logic                 we_i,
   input  logic [31:0]          adr_i,
   input  logic [DataWidth-1:0] dat_i,
   output logic [DataWidth-1:0] dat_o,
   output logic                 ack_o,
   input  logic                 inst_cyc_i,
   input  logic [PC_W-1:0]      inst_pc_i,
   output logic [DataWidth-1:0] inst_o,
   output logic                 inst_ack_o
);

   localparam logic [3:0] WaitLast =
      (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   sm_e                  state_q, state_d;
   port_e                port_q, port_d;
   logic                 we_q, we_d;
   logic                 oor_q, oor_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DataWidth-1:0] wdat_q, wdat_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 ack_q, ack_d;
   logic                 iack_q, iack_d;

   logic                 gnt_cyc;
   logic                 ram_en;
   logic                 ram_we;
   logic [DataWidth-1:0] ram_rdat;
   logic                 unused_pc;

   // Upper PC bits deliberately ignored: fetches wrap onto the RAM.
   assign unused_pc = ^inst_pc_i;

   assign gnt_cyc = (port_q == PORT_INST) ? inst_cyc_i : cyc_i;

   always_comb begin
      state_d = state_q;
      port_d  = port_q;
      we_d    = we_q;
      oor_d   = oor_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         SM_IDLE: begin
            if (cyc_i) begin
               port_d  = PORT_DATA;
               we_d    = we_i;
               oor_d   = adr_oor(adr_i, ADDR_W);
               addr_d  = adr_i[ADDR_W-1:0];
               wdat_d  = dat_i;
               state_d = SM_ACCESS;
            end else if (inst_cyc_i) begin
               port_d  = PORT_INST;
               we_d    = 1'b0;
               oor_d   = 1'b0;
               addr_d  = inst_pc_i[ADDR_W-1:0];
               state_d = SM_ACCESS;
            end
         end
         SM_ACCESS: begin
            if (!gnt_cyc) begin
               state_d = SM_IDLE;
            end else if (WAIT_STATES > 0) begin
               cnt_d   = 4'd0;
               state_d = SM_WAIT;
            end else begin
               state_d = SM_RESP;
            end
         end
         SM_WAIT: begin
            if (!gnt_cyc) begin
               state_d = SM_IDLE;
            end else if (cnt_q == WaitLast) begin
               state_d = SM_RESP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         SM_RESP: begin
            state_d = SM_IDLE;
         end
         default: begin
            state_d = SM_IDLE;
         end
      endcase
   end

   // Acks are registered on entry to RESP, so they last exactly one cycle.
   assign ack_d  = (state_d == SM_RESP) && (port_q == PORT_DATA);
   assign iack_d = (state_d == SM_RESP) && (port_q == PORT_INST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SM_IDLE;
         port_q  <= PORT_DATA;
         we_q    <= 1'b0;
         oor_q   <= 1'b0;
         addr_q  <= '0;
         wdat_q  <= ZeroWord;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         iack_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         we_q    <= we_d;
         oor_q   <= oor_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         iack_q  <= iack_d;
      end
   end

   // A write committed in ACCESS stays committed even if the master aborts.
   assign ram_en = (state_q == SM_ACCESS);
   assign ram_we = ram_en && we_q && !oor_q;

   wb_spram #(
      .AW (ADDR_W),
      .DW (DataWidth)
   ) u_ram (
      .clk  (clk),
      .en   (ram_en),
      .we   (ram_we),
      .adr  (addr_q),
      .wdat (wdat_q),
      .rdat (ram_rdat)
   );

   // RAM output register holds its value through WAIT; gate it onto the bus
   // only in the ack cycle so outputs read zero otherwise.
   assign ack_o      = ack_q;
   assign inst_ack_o = iack_q;
   assign dat_o      = (ack_q && !we_q && !oor_q) ? ram_rdat : ZeroWord;
   assign inst_o     = iack_q ? ram_rdat : ZeroWord;

endmodule

// File: tb/tb_wb_j1_shared_mem_slave.sv
// Directed testbench for wb_j1_shared_mem_slave.
// Two instances: u_dut0 with no wait states, u_dut3 with three.
module tb_wb_j1_shared_mem_slave;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   logic        c0, w0, k0, ic0, ik0;
   logic [31:0] a0, di0, do0, in0;
   logic [13:0] pc0;

   logic        c3, w3, k3, ic3, ik3;
   logic [31:0] a3, di3, do3, in3;
   logic [13:0] pc3;

   int n_chk  = 0;
   int n_fail = 0;

   wb_j1_shared_mem_slave #(
      .ADDR_W (12), .PC_W (14), .WAIT_STATES (0)
   ) u_dut0 (
      .clk (clk), .rst (rst),
      .cyc_i (c0), .we_i (w0), .adr_i (a0), .dat_i (di0),
      .dat_o (do0), .ack_o (k0),
      .inst_cyc_i (ic0), .inst_pc_i (pc0),
      .inst_o (in0), .inst_ack_o (ik0)
   );

   wb_j1_shared_mem_slave #(
      .ADDR_W (12), .PC_W (14), .WAIT_STATES (3)
   ) u_dut3 (
      .clk (clk), .rst (rst),
      .cyc_i (c3), .we_i (w3), .adr_i (a3), .dat_i (di3),
      .dat_o (do3), .ack_o (k3),
      .inst_cyc_i (ic3), .inst_pc_i (pc3),
      .inst_o (in3), .inst_ack_o (ik3)
   );

   task automatic d0_op(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat,
                        output int lat, output logic [31:0] rd);
      @(posedge clk); #1;
      c0 = 1'b1; w0 = we; a0 = adr; di0 = dat;
      lat = -1; rd = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (k0) begin lat = i; rd = do0; break; end
      end
      c0 = 1'b0; w0 = 1'b0;
   endtask

   task automatic d3_op(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat,
                        output int lat, output logic [31:0] rd);
      @(posedge clk); #1;
      c3 = 1'b1; w3 = we; a3 = adr; di3 = dat;
      lat = -1; rd = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (k3) begin lat = i; rd = do3; break; end
      end
      c3 = 1'b0; w3 = 1'b0;
   endtask

   task automatic f0_op(input logic [13:0] pc,
                        output int lat, output logic [31:0] rd);
      @(posedge clk); #1;
      ic0 = 1'b1; pc0 = pc;
      lat = -1; rd = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ik0) begin lat = i; rd = in0; break; end
      end
      ic0 = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      c0 = 0; w0 = 0; a0 = 0; di0 = 0; ic0 = 0; pc0 = 0;
      c3 = 0; w3 = 0; a3 = 0; di3 = 0; ic3 = 0; pc3 = 0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (k0 !== 1'b0 || ik0 !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_acks0: got %b/%b expected 0/0", k0, ik0);
      end
      n_chk++;
      if (do0 !== 32'd0 || in0 !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_data0: got %h/%h expected 0/0", do0, in0);
      end
      n_chk++;
      if (k3 !== 1'b0 || ik3 !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_acks3: got %b/%b expected 0/0", k3, ik3);
      end
      n_chk++;
      if (do3 !== 32'd0 || in3 !== 32'd0) begin
         n_fail++;
         $display("FAIL rst_data3: got %h/%h expected 0/0", do3, in3);
      end
      rst = 1'b1;
   endtask

   task automatic test_write_read;
      int lat;
      logic [31:0] rd;
      d0_op(1'b1, 32'h10, 32'hDEADBEEF, lat, rd);
      n_chk++;
      if (lat !== 2) begin
         n_fail++;
         $display("FAIL wr_lat: got %0d expected 2", lat);
      end
      d0_op(1'b0, 32'h10, 32'h0, lat, rd);
      n_chk++;
      if (lat !== 2) begin
         n_fail++;
         $display("FAIL rd_lat: got %0d expected 2", lat);
      end
      n_chk++;
      if (rd !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL rd_data: got %h expected deadbeef", rd);
      end
      @(negedge clk);
      n_chk++;
      if (k0 !== 1'b0 || do0 !== 32'd0) begin
         n_fail++;
         $display("FAIL ack_width: got ack=%b dat=%h expected 0/0", k0, do0);
      end
   endtask

   task automatic test_back_to_back;
      int first, second;
      first = -1; second = -1;
      @(posedge clk); #1;
      c0 = 1'b1; w0 = 1'b0; a0 = 32'h10;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (k0) begin
            if (first < 0) first = i;
            else if (second < 0) second = i;
         end
      end
      c0 = 1'b0;
      n_chk++;
      if (first !== 2) begin
         n_fail++;
         $display("FAIL b2b_first: got %0d expected 2", first);
      end
      n_chk++;
      if (second !== 5) begin
         n_fail++;
         $display("FAIL b2b_second: got %0d expected 5", second);
      end
   endtask

   task automatic test_priority;
      int lat, dack, iack;
      logic both;
      logic [31:0] rd, drd, ird;
      d0_op(1'b1, 32'h5, 32'h12345005, lat, rd);
      dack = -1; iack = -1; both = 1'b0; drd = '0; ird = '0;
      @(posedge clk); #1;
      c0 = 1'b1; w0 = 1'b0; a0 = 32'h10;
      ic0 = 1'b1; pc0 = 14'h005;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (k0 && ik0) both = 1'b1;
         if (k0 && dack < 0) begin dack = i; drd = do0; c0 = 1'b0; end
         if (ik0 && iack < 0) begin iack = i; ird = in0; ic0 = 1'b0; end
      end
      c0 = 1'b0; ic0 = 1'b0;
      n_chk++;
      if (dack !== 2) begin
         n_fail++;
         $display("FAIL prio_dack: got %0d expected 2", dack);
      end
      n_chk++;
      if (iack !== 5) begin
         n_fail++;
         $display("FAIL prio_iack: got %0d expected 5", iack);
      end
      n_chk++;
      if (drd !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL prio_ddata: got %h expected deadbeef", drd);
      end
      n_chk++;
      if (ird !== 32'h12345005) begin
         n_fail++;
         $display("FAIL prio_idata: got %h expected 12345005", ird);
      end
      n_chk++;
      if (both !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_both: got %b expected 0", both);
      end
   endtask

   task automatic test_out_of_range;
      int lat;
      logic [31:0] rd;
      d0_op(1'b1, 32'h0, 32'hA5A50000, lat, rd);
      d0_op(1'b0, 32'h0000_1000, 32'h0, lat, rd);
      n_chk++;
      if (lat !== 2) begin
         n_fail++;
         $display("FAIL oor_rd_lat: got %0d expected 2", lat);
      end
      n_chk++;
      if (rd !== 32'd0) begin
         n_fail++;
         $display("FAIL oor_rd_data: got %h expected 0", rd);
      end
      d0_op(1'b1, 32'h0000_1000, 32'hFFFFFFFF, lat, rd);
      n_chk++;
      if (lat !== 2) begin
         n_fail++;
         $display("FAIL oor_wr_lat: got %0d expected 2", lat);
      end
      d0_op(1'b0, 32'h0, 32'h0, lat, rd);
      n_chk++;
      if (rd !== 32'hA5A50000) begin
         n_fail++;
         $display("FAIL oor_ram0: got %h expected a5a50000", rd);
      end
   endtask

   task automatic test_pc_wrap;
      int lat;
      logic [31:0] rd;
      f0_op(14'h3005, lat, rd);
      n_chk++;
      if (lat !== 2) begin
         n_fail++;
         $display("FAIL pc_lat: got %0d expected 2", lat);
      end
      n_chk++;
      if (rd !== 32'h12345005) begin
         n_fail++;
         $display("FAIL pc_wrap: got %h expected 12345005", rd);
      end
   endtask

   task automatic test_async_reset_ack;
      int lat;
      logic late;
      lat = -1; late = 1'b0;
      @(posedge clk); #1;
      c0 = 1'b1; w0 = 1'b0; a0 = 32'h10;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (k0) begin lat = i; break; end
      end
      #1 rst = 1'b0;
      #1;
      n_chk++;
      if (lat !== 2) begin
         n_fail++;
         $display("FAIL arst_pre_lat: got %0d expected 2", lat);
      end
      n_chk++;
      if (k0 !== 1'b0 || do0 !== 32'd0) begin
         n_fail++;
         $display("FAIL arst_drop: got ack=%b dat=%h expected 0/0", k0, do0);
      end
      c0 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (k0 || ik0) late = 1'b1;
      end
      n_chk++;
      if (late !== 1'b0) begin
         n_fail++;
         $display("FAIL arst_noack: got %b expected 0", late);
      end
   endtask

   task automatic test_wait_states;
      int lat;
      logic leak;
      logic [31:0] rd;
      d3_op(1'b1, 32'h20, 32'hCAFEF00D, lat, rd);
      n_chk++;
      if (lat !== 5) begin
         n_fail++;
         $display("FAIL ws_wr_lat: got %0d expected 5", lat);
      end
      lat = -1; leak = 1'b0; rd = '0;
      @(posedge clk); #1;
      c3 = 1'b1; w3 = 1'b0; a3 = 32'h20;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (k3 && lat < 0) begin lat = i; rd = do3; c3 = 1'b0; end
         else if (do3 !== 32'd0) leak = 1'b1;
      end
      c3 = 1'b0;
      n_chk++;
      if (lat !== 5) begin
         n_fail++;
         $display("FAIL ws_rd_lat: got %0d expected 5", lat);
      end
      n_chk++;
      if (rd !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL ws_rd_data: got %h expected cafef00d", rd);
      end
      n_chk++;
      if (leak !== 1'b0) begin
         n_fail++;
         $display("FAIL ws_dat_idle: got %b expected 0", leak);
      end
   endtask

   task automatic test_reset_in_wait;
      int lat;
      logic late;
      logic [31:0] rd;
      late = 1'b0;
      @(posedge clk); #1;
      c3 = 1'b1; w3 = 1'b1; a3 = 32'h30; di3 = 32'h11111111;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      c3 = 1'b0; w3 = 1'b0;
      #1;
      n_chk++;
      if (k3 !== 1'b0 || ik3 !== 1'b0) begin
         n_fail++;
         $display("FAIL rw_acks: got %b/%b expected 0/0", k3, ik3);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (k3 || ik3) late = 1'b1;
      end
      n_chk++;
      if (late !== 1'b0) begin
         n_fail++;
         $display("FAIL rw_noack: got %b expected 0", late);
      end
      d3_op(1'b0, 32'h30, 32'h0, lat, rd);
      n_chk++;
      if (lat !== 5 || rd !== 32'h11111111) begin
         n_fail++;
         $display("FAIL rw_after: got lat=%0d dat=%h expected 5/11111111",
                  lat, rd);
      end
   endtask

   task automatic test_abort;
      int lat;
      logic [31:0] rd;
      @(posedge clk); #1;
      c3 = 1'b1; w3 = 1'b0; a3 = 32'h30;
      repeat (3) @(negedge clk);
      c3 = 1'b0;
      @(posedge clk); #1;
      c3 = 1'b1; w3 = 1'b0; a3 = 32'h20;
      lat = -1; rd = '0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (k3) begin lat = i; rd = do3; break; end
      end
      c3 = 1'b0;
      n_chk++;
      if (lat !== 5) begin
         n_fail++;
         $display("FAIL abort_lat: got %0d expected 5", lat);
      end
      n_chk++;
      if (rd !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL abort_data: got %h expected cafef00d", rd);
      end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_back_to_back;
      test_priority;
      test_out_of_range;
      test_pc_wrap;
      test_async_reset_ack;
      test_wait_states;
      test_reset_in_wait;
      test_abort;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
